// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - stage-side sequencing signals shared between the core pipeline and its hazard controller
interface pipeline_hazard_ctrl_if;
    logic [4:0]  src1_ID;
    logic [4:0]  src2_ID;
    logic        two_src_ID;
    logic [4:0]  dest_EXE;
    logic        WB_En_EXE;
    logic        MEM_R_EN_EXE;
    logic [4:0]  dest_MEM;
    logic        WB_En_MEM;
    logic        fwd_en;
    logic        BrTaken;
    logic        mem_r_req;
    logic        mem_w_req;
    logic        sram_ready;
    logic        hazard_stall;
    logic        flush;
    logic        freeze;
    logic        sram_start;
    logic        sram_err;
    logic [31:0] stall_cycles;

    modport master (
        output src1_ID, src2_ID, two_src_ID, dest_EXE, WB_En_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_En_MEM, fwd_en, BrTaken, mem_r_req, mem_w_req, sram_ready,
        input  hazard_stall, flush, freeze, sram_start, sram_err, stall_cycles
    );

    modport slave (
        input  src1_ID, src2_ID, two_src_ID, dest_EXE, WB_En_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_En_MEM, fwd_en, BrTaken, mem_r_req, mem_w_req, sram_ready,
        output hazard_stall, flush, freeze, sram_start, sram_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall, branch flush and SRAM freeze sequencer for the 5-stage core
module pipeline_hazard_ctrl #(
    parameter int unsigned MIN_WAIT = 5,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic [31:0]   stall_q;

    logic src1_hit;
    logic src2_hit;
    logic hit;
    logic mem_req;
    logic frz;
    logic start_now;
    logic stall_now;
    logic ready_ok;
    logic timeout_hit;

    // With forwarding only a load in EXE cannot supply its result in time.
    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        if (bus.fwd_en) begin
            src1_hit = (bus.src1_ID == bus.dest_EXE) && bus.MEM_R_EN_EXE;
            src2_hit = (bus.src2_ID == bus.dest_EXE) && bus.MEM_R_EN_EXE;
        end else begin
            src1_hit = ((bus.src1_ID == bus.dest_EXE) && bus.WB_En_EXE) ||
                       ((bus.src1_ID == bus.dest_MEM) && bus.WB_En_MEM);
            src2_hit = ((bus.src2_ID == bus.dest_EXE) && bus.WB_En_EXE) ||
                       ((bus.src2_ID == bus.dest_MEM) && bus.WB_En_MEM);
        end
        hit = (src1_hit && (bus.src1_ID != 5'd0)) ||
              (src2_hit && bus.two_src_ID && (bus.src2_ID != 5'd0));
    end

    assign mem_req     = bus.mem_r_req | bus.mem_w_req;
    assign start_now   = ~rst & (state == IDLE) & mem_req;
    assign frz         = start_now | (~rst & (state == WAIT));
    assign stall_now   = ~rst & hit & ~bus.BrTaken & ~frz;
    assign ready_ok    = bus.sram_ready && (wait_cnt >= CW'(MIN_WAIT - 1));
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    // A branch held in EXE across a freeze flushes on the first unfrozen cycle.
    assign bus.flush        = ~rst & bus.BrTaken & ~frz;
    assign bus.hazard_stall = stall_now;
    assign bus.freeze       = frz;
    assign bus.sram_start   = start_now;
    assign bus.sram_err     = err_q;
    assign bus.stall_cycles = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (ready_ok) begin
                        state <= DONE;
                    end else if (timeout_hit) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // DONE lets MEM advance so the finished request is not re-issued.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((stall_now || frz) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl with a reference model
module tb_pipeline_hazard_ctrl;
    localparam int unsigned MIN_WAIT = 5;
    localparam int unsigned TIMEOUT  = 64;

    typedef struct packed {
        logic        hs;
        logic        fl;
        logic        fz;
        logic        st;
        logic        er;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: an access is tracked by its age in cycles since the start strobe.
    bit          m_active = 0;
    bit          m_done   = 0;
    int          m_age    = 0;
    bit          m_err    = 0;
    logic [31:0] m_cnt    = '0;

    function automatic bit needs_stall(input logic [4:0] src);
        if (src == 5'd0) return 1'b0;
        if (bus.fwd_en) return (src == bus.dest_EXE) && bus.MEM_R_EN_EXE;
        return ((src == bus.dest_EXE) && bus.WB_En_EXE) || ((src == bus.dest_MEM) && bus.WB_En_MEM);
    endfunction

    task automatic step();
        exp_t e;
        bit req, fz, st, rdy_ok, to, ends, hit;
        e = '0;
        if (rst) begin
            e.er = m_err;
            e.cnt = m_cnt;
            m_active = 0; m_done = 0; m_age = 0; m_err = 0; m_cnt = '0;
        end else begin
            req = bus.mem_r_req || bus.mem_w_req;
            fz = 0; st = 0; to = 0; ends = 0;
            if (m_done) begin
                fz = 0;
            end else if (!m_active) begin
                st = req;
                fz = req;
            end else begin
                fz = 1;
                rdy_ok = bus.sram_ready && (m_age >= int'(MIN_WAIT));
                to = !rdy_ok && (m_age == int'(TIMEOUT));
                ends = rdy_ok || to;
            end
            hit = needs_stall(bus.src1_ID) || (bus.two_src_ID && needs_stall(bus.src2_ID));
            e.fz = fz;
            e.st = st;
            e.fl = bus.BrTaken && !fz;
            e.hs = hit && !bus.BrTaken && !fz;
            e.er = m_err;
            e.cnt = m_cnt;
            if ((e.hs || fz) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_done) m_done = 0;
            else if (!m_active) begin
                if (req) begin m_active = 1; m_age = 1; end
            end else if (ends) begin
                m_active = 0; m_done = 1;
                if (to) m_err = 1;
            end else m_age++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hazard_stall", {31'd0, bus.hazard_stall}, {31'd0, e.hs});
                chk("flush",        {31'd0, bus.flush},        {31'd0, e.fl});
                chk("freeze",       {31'd0, bus.freeze},       {31'd0, e.fz});
                chk("sram_start",   {31'd0, bus.sram_start},   {31'd0, e.st});
                chk("sram_err",     {31'd0, bus.sram_err},     {31'd0, e.er});
                chk("stall_cycles", bus.stall_cycles,          e.cnt);
            end
        end
    end

    task automatic clear_inputs();
        bus.src1_ID = '0; bus.src2_ID = '0; bus.two_src_ID = 0;
        bus.dest_EXE = '0; bus.WB_En_EXE = 0; bus.MEM_R_EN_EXE = 0;
        bus.dest_MEM = '0; bus.WB_En_MEM = 0; bus.fwd_en = 0; bus.BrTaken = 0;
        bus.mem_r_req = 0; bus.mem_w_req = 0; bus.sram_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();
        step();

        // RAW without forwarding, then register 0 never matches
        bus.dest_EXE = 5'd3; bus.WB_En_EXE = 1; bus.src1_ID = 5'd3; step();
        bus.src1_ID = 5'd0; step();
        bus.dest_EXE = 5'd0; bus.src1_ID = 5'd0; step();

        // load-use with forwarding on src2
        clear_inputs();
        bus.fwd_en = 1; bus.dest_EXE = 5'd5; bus.MEM_R_EN_EXE = 1; bus.WB_En_EXE = 1;
        bus.two_src_ID = 1; bus.src2_ID = 5'd5; bus.src1_ID = 5'd1; step();
        bus.MEM_R_EN_EXE = 0; step();
        bus.two_src_ID = 0; bus.MEM_R_EN_EXE = 1; step();

        // taken branch beats a hazard hit
        clear_inputs();
        bus.dest_MEM = 5'd7; bus.WB_En_MEM = 1; bus.src1_ID = 5'd7; bus.BrTaken = 1; step();
        clear_inputs(); step();

        // minimum-latency load with ready asserted early
        do_reset();
        bus.mem_r_req = 1; bus.sram_ready = 1;
        repeat (7) step();
        clear_inputs(); step(); step();

        // timeout with a branch held during the freeze
        do_reset();
        bus.mem_w_req = 1; bus.BrTaken = 1;
        repeat (TIMEOUT + 2) step();
        bus.mem_w_req = 0;
        repeat (3) step();
        clear_inputs(); step();

        // reset in the middle of an access
        bus.mem_r_req = 1;
        repeat (3) step();
        do_reset();
        bus.mem_r_req = 0; step(); step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.src1_ID = 5'($urandom_range(0, 3));
            bus.src2_ID = 5'($urandom_range(0, 3));
            bus.two_src_ID = 1'($urandom);
            bus.dest_EXE = 5'($urandom_range(0, 3));
            bus.dest_MEM = 5'($urandom_range(0, 3));
            bus.WB_En_EXE = 1'($urandom);
            bus.WB_En_MEM = 1'($urandom);
            bus.MEM_R_EN_EXE = 1'($urandom);
            bus.fwd_en = 1'($urandom);
            bus.BrTaken = ($urandom_range(0, 4) == 0);
            bus.mem_r_req = ($urandom_range(0, 5) == 0);
            bus.mem_w_req = ($urandom_range(0, 7) == 0);
            bus.sram_ready = ($urandom_range(0, 9) != 0) ? 1'($urandom) : 1'b0;
            if (i % 500 > 420) bus.sram_ready = 0;
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
